// File: rtl/dma_pkg.sv
// Shared types and default widths for the simple_dma ring scheduler.
package dma_pkg;

  localparam int unsigned ADR_W_DEF  = 28;
  localparam int unsigned NBUF_W_DEF = 12;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned LINE_WORDS = 972;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    GAP   = 3'd4,
    DRAIN = 3'd5
  } state_e;

endpackage

// File: rtl/ring_ptr.sv
// Modulo-buf_num ring index: advances by step_i each cycle, cleared by clr_i.
module ring_ptr
  import dma_pkg::*;
#(
  parameter int unsigned NBUF_W = NBUF_W_DEF
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              clr_i,
  input  logic [NBUF_W-1:0] step_i,
  input  logic [NBUF_W-1:0] buf_num_i,
  output logic [NBUF_W-1:0] idx_o
);

  localparam int unsigned SW = NBUF_W + 1;

  logic [NBUF_W-1:0] idx_q, idx_d;
  logic [SW-1:0]     sum;

  // step is never larger than buf_num, so one conditional subtract wraps
  always_comb begin
    sum = SW'(idx_q) + SW'(step_i);
    if (sum >= SW'(buf_num_i)) begin
      sum = sum - SW'(buf_num_i);
    end
    idx_d = clr_i ? '0 : sum[NBUF_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/dma_ring_scheduler.sv
// Issues simple_dma commands into a ring of equal-size SDRAM buffers and
// tracks completions, fill level and write index for the host.
module dma_ring_scheduler
  import dma_pkg::*;
#(
  parameter int unsigned ADR_W           = ADR_W_DEF,
  parameter int unsigned NBUF_W          = NBUF_W_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned MAX_OUTSTANDING = 1
) (
  input  logic              CLK,
  input  logic              SRST,
  input  logic [ADR_W-1:0]  CFG_BASE_ADR,
  input  logic [ADR_W-1:0]  CFG_BUF_SIZE,
  input  logic [NBUF_W-1:0] CFG_BUF_NUM,
  input  logic              CFG_CYCLIC,
  input  logic [CNT_W-1:0]  CFG_TOTAL,
  input  logic              RUN,
  input  logic              HOST_RELEASE,
  input  logic [CNT_W-1:0]  DMA_DONE_CNT,
  output logic              DMA_START,
  output logic [ADR_W-1:0]  DMA_START_ADR,
  output logic [ADR_W-1:0]  DMA_BUF_SIZE,
  output logic              BUSY,
  output logic [NBUF_W-1:0] WR_IDX,
  output logic [NBUF_W-1:0] FILLED,
  output logic [CNT_W-1:0]  DONE_TOTAL,
  output logic              IRQ,
  output logic              OVERRUN,
  output logic              ERR,
  output logic              FINISHED
);

  localparam int unsigned FW = NBUF_W + 1;

  state_e            state_q, state_d;
  logic              run_prev_q, run_prev_d;
  logic [CNT_W-1:0]  done_prev_q, done_prev_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [ADR_W-1:0]  base_q, base_d;
  logic [ADR_W-1:0]  size_q, size_d;
  logic [NBUF_W-1:0] num_q, num_d;
  logic              cyclic_q, cyclic_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [ADR_W-1:0]  issue_adr_q, issue_adr_d;
  logic              start_q, start_d;
  logic [ADR_W-1:0]  start_adr_q, start_adr_d;
  logic [ADR_W-1:0]  start_size_q, start_size_d;
  logic [NBUF_W-1:0] filled_q, filled_d;
  logic [CNT_W-1:0]  done_total_q, done_total_d;
  logic              irq_q, irq_d;
  logic              overrun_q, overrun_d;
  logic              err_q, err_d;
  logic              finished_q, finished_d;
  logic              busy_q, busy_d;

  logic [CNT_W-1:0]  delta_c, k_c;
  logic              over_c, rel_c, total_hit_c, can_issue_c;
  logic              issue_c, arm_c, issue_wrap_c;
  logic [NBUF_W-1:0] fill_base_c, issue_idx;
  logic [FW-1:0]     fill_sum_c, occ_c;

  ring_ptr #(.NBUF_W(NBUF_W)) u_issue_ptr (
    .clk_i     (CLK),
    .srst_i    (SRST),
    .clr_i     (arm_c),
    .step_i    (NBUF_W'(issue_c)),
    .buf_num_i (num_q),
    .idx_o     (issue_idx)
  );

  ring_ptr #(.NBUF_W(NBUF_W)) u_wr_ptr (
    .clk_i     (CLK),
    .srst_i    (SRST),
    .clr_i     (arm_c),
    .step_i    (NBUF_W'(k_c)),
    .buf_num_i (num_q),
    .idx_o     (WR_IDX)
  );

  always_comb begin
    state_d       = state_q;
    run_prev_d    = RUN;
    done_prev_d   = DMA_DONE_CNT;
    issued_d      = issued_q;
    base_d        = base_q;
    size_d        = size_q;
    num_d         = num_q;
    cyclic_d      = cyclic_q;
    total_d       = total_q;
    issue_adr_d   = issue_adr_q;
    start_d       = 1'b0;
    start_adr_d   = start_adr_q;
    start_size_d  = start_size_q;
    overrun_d     = overrun_q;
    finished_d    = finished_q;
    arm_c         = 1'b0;
    issue_c       = 1'b0;

    // Completions are clipped to what was actually issued; excess is an error
    delta_c      = DMA_DONE_CNT - done_prev_q;
    over_c       = (delta_c > outstanding_q);
    k_c          = over_c ? outstanding_q : delta_c;
    rel_c        = HOST_RELEASE && (filled_q != '0);
    fill_base_c  = filled_q - NBUF_W'(rel_c);
    fill_sum_c   = FW'(fill_base_c) + FW'(k_c);
    occ_c        = FW'(filled_q) + FW'(outstanding_q);
    issue_wrap_c = (issue_idx == (num_q - NBUF_W'(1)));
    total_hit_c  = (total_q != '0) && (issued_q == total_q);
    can_issue_c  = (outstanding_q < CNT_W'(MAX_OUTSTANDING))
                && ((total_q == '0) || (issued_q < total_q))
                && (cyclic_q || (occ_c < FW'(num_q)));

    outstanding_d = outstanding_q - k_c;
    done_total_d  = done_total_q + k_c;
    irq_d         = (k_c != '0);
    err_d         = err_q | over_c;
    if (fill_sum_c > FW'(num_q)) begin
      filled_d = num_q;
      if (cyclic_q) overrun_d = 1'b1;
      else          err_d     = 1'b1;
    end else begin
      filled_d = fill_sum_c[NBUF_W-1:0];
    end

    case (state_q)
      IDLE: begin
        if (RUN && !run_prev_q) state_d = ARM;
      end
      ARM: begin
        arm_c        = 1'b1;
        base_d       = CFG_BASE_ADR;
        size_d       = CFG_BUF_SIZE;
        num_d        = CFG_BUF_NUM;
        cyclic_d     = CFG_CYCLIC;
        total_d      = CFG_TOTAL;
        issue_adr_d  = CFG_BASE_ADR;
        filled_d     = '0;
        done_total_d = '0;
        issued_d     = '0;
        overrun_d    = 1'b0;
        err_d        = over_c;
        finished_d   = 1'b0;
        state_d      = WAIT;
      end
      WAIT: begin
        if (!RUN || total_hit_c) begin
          state_d = DRAIN;
        end else if (can_issue_c) begin
          issue_c       = 1'b1;
          start_d       = 1'b1;
          start_adr_d   = issue_adr_q;
          start_size_d  = size_q;
          outstanding_d = outstanding_d + CNT_W'(1);
          issued_d      = issued_q + CNT_W'(1);
          issue_adr_d   = issue_wrap_c ? base_q : (issue_adr_q + size_q);
          state_d       = ISSUE;
        end
      end
      ISSUE: state_d = GAP;
      GAP:   state_d = WAIT;
      DRAIN: begin
        if (outstanding_q == '0) begin
          if (total_hit_c) finished_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      state_q       <= IDLE;
      run_prev_q    <= 1'b0;
      done_prev_q   <= DMA_DONE_CNT;
      outstanding_q <= '0;
      issued_q      <= '0;
      base_q        <= '0;
      size_q        <= '0;
      num_q         <= '0;
      cyclic_q      <= 1'b0;
      total_q       <= '0;
      issue_adr_q   <= '0;
      start_q       <= 1'b0;
      start_adr_q   <= '0;
      start_size_q  <= '0;
      filled_q      <= '0;
      done_total_q  <= '0;
      irq_q         <= 1'b0;
      overrun_q     <= 1'b0;
      err_q         <= 1'b0;
      finished_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_prev_q    <= run_prev_d;
      done_prev_q   <= done_prev_d;
      outstanding_q <= outstanding_d;
      issued_q      <= issued_d;
      base_q        <= base_d;
      size_q        <= size_d;
      num_q         <= num_d;
      cyclic_q      <= cyclic_d;
      total_q       <= total_d;
      issue_adr_q   <= issue_adr_d;
      start_q       <= start_d;
      start_adr_q   <= start_adr_d;
      start_size_q  <= start_size_d;
      filled_q      <= filled_d;
      done_total_q  <= done_total_d;
      irq_q         <= irq_d;
      overrun_q     <= overrun_d;
      err_q         <= err_d;
      finished_q    <= finished_d;
      busy_q        <= busy_d;
    end
  end

  assign DMA_START     = start_q;
  assign DMA_START_ADR = start_adr_q;
  assign DMA_BUF_SIZE  = start_size_q;
  assign BUSY          = busy_q;
  assign FILLED        = filled_q;
  assign DONE_TOTAL    = done_total_q;
  assign IRQ           = irq_q;
  assign OVERRUN       = overrun_q;
  assign ERR           = err_q;
  assign FINISHED      = finished_q;

endmodule

// File: tb/tb_dma_ring_scheduler.sv
// Directed bench for dma_ring_scheduler; the bench plays simple_dma and the host.
module tb_dma_ring_scheduler;
  import dma_pkg::*;

  localparam int unsigned ADR_W  = 28;
  localparam int unsigned NBUF_W = 12;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              srst;
  logic [ADR_W-1:0]  cfg_base, cfg_size;
  logic [NBUF_W-1:0] cfg_num;
  logic              cfg_cyc;
  logic [CNT_W-1:0]  cfg_total;
  logic              run, rel;
  logic [CNT_W-1:0]  done_cnt;
  logic              dma_start, busy, irq, overrun, err, finished;
  logic [ADR_W-1:0]  start_adr, buf_size;
  logic [NBUF_W-1:0] wr_idx, filled;
  logic [CNT_W-1:0]  done_total;

  int n_chk = 0;
  int n_pass = 0;
  int start_cnt = 0;
  int irq_cnt = 0;
  int snap;

  always #5 clk = ~clk;

  dma_ring_scheduler dut (
    .CLK(clk), .SRST(srst),
    .CFG_BASE_ADR(cfg_base), .CFG_BUF_SIZE(cfg_size), .CFG_BUF_NUM(cfg_num),
    .CFG_CYCLIC(cfg_cyc), .CFG_TOTAL(cfg_total),
    .RUN(run), .HOST_RELEASE(rel), .DMA_DONE_CNT(done_cnt),
    .DMA_START(dma_start), .DMA_START_ADR(start_adr), .DMA_BUF_SIZE(buf_size),
    .BUSY(busy), .WR_IDX(wr_idx), .FILLED(filled), .DONE_TOTAL(done_total),
    .IRQ(irq), .OVERRUN(overrun), .ERR(err), .FINISHED(finished)
  );

  always @(posedge clk) begin
    if (dma_start) start_cnt++;
    if (irq) irq_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"},   64'(dma_start),  0);
    chk({tag, "_adr"},     64'(start_adr),  0);
    chk({tag, "_size"},    64'(buf_size),   0);
    chk({tag, "_busy"},    64'(busy),       0);
    chk({tag, "_wridx"},   64'(wr_idx),     0);
    chk({tag, "_filled"},  64'(filled),     0);
    chk({tag, "_total"},   64'(done_total), 0);
    chk({tag, "_irq"},     64'(irq),        0);
    chk({tag, "_ovr"},     64'(overrun),    0);
    chk({tag, "_err"},     64'(err),        0);
    chk({tag, "_fin"},     64'(finished),   0);
  endtask

  task automatic do_reset();
    srst = 1'b1; run = 1'b0; rel = 1'b0;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
  endtask

  task automatic start_run(input int base, input int size, input int num,
                           input bit cyc, input int total);
    cfg_base  = ADR_W'(base);
    cfg_size  = ADR_W'(size);
    cfg_num   = NBUF_W'(num);
    cfg_cyc   = cyc;
    cfg_total = CNT_W'(total);
    @(posedge clk); #1 run = 1'b1;
  endtask

  // Returns on the negedge where DMA_START is high
  task automatic wait_start(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (dma_start) seen = 1'b1;
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    bit idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic complete_one();
    @(posedge clk); #1 done_cnt = done_cnt + CNT_W'(1);
  endtask

  task automatic serve(input string tag, input int exp_adr);
    wait_start(tag);
    chk(tag, 64'(start_adr), 64'(exp_adr));
    complete_one();
  endtask

  task automatic pulse_release();
    @(posedge clk); #1 rel = 1'b1;
    @(posedge clk); #1 rel = 1'b0;
  endtask

  initial begin
    cfg_base = '0; cfg_size = '0; cfg_num = '0; cfg_cyc = 1'b0; cfg_total = '0;
    run = 1'b0; rel = 1'b0; done_cnt = '0; srst = 1'b1;

    // 1: non-cyclic ring of 4 stalls when full, one release frees a slot
    do_reset();
    @(negedge clk);
    chk_zero("rst");
    start_run(0, LINE_WORDS, 4, 1'b0, 0);
    snap = start_cnt;
    serve("t1_a0", 0);
    chk("t1_size", 64'(buf_size), 64'(LINE_WORDS));
    cfg_base = ADR_W'(5000); cfg_size = ADR_W'(1); cfg_num = NBUF_W'(2);
    serve("t1_a1", 972);
    serve("t1_a2", 1944);
    serve("t1_a3", 2916);
    repeat (20) @(negedge clk);
    chk("t1_filled4", 64'(filled), 4);
    chk("t1_nstart4", 64'(start_cnt - snap), 4);
    chk("t1_stall_busy", 64'(busy), 1);
    chk("t1_hold_adr", 64'(start_adr), 2916);
    pulse_release();
    wait_start("t1_a4");
    chk("t1_a4", 64'(start_adr), 0);
    chk("t1_filled3", 64'(filled), 3);
    complete_one();
    @(posedge clk); #1 run = 1'b0;
    wait_idle("t1_idle");
    chk("t1_wridx", 64'(wr_idx), 1);
    chk("t1_total", 64'(done_total), 5);
    chk("t1_nstart5", 64'(start_cnt - snap), 5);
    chk("t1_err", 64'(err), 0);

    // 2: cyclic ring of 2 overwrites unreleased buffers
    do_reset();
    start_run(0, LINE_WORDS, 2, 1'b1, 5);
    serve("t2_a0", 0);
    serve("t2_a1", 972);
    serve("t2_a2", 0);
    serve("t2_a3", 972);
    serve("t2_a4", 0);
    wait_idle("t2_idle");
    chk("t2_filled", 64'(filled), 2);
    chk("t2_ovr", 64'(overrun), 1);
    chk("t2_wridx", 64'(wr_idx), 1);
    chk("t2_total", 64'(done_total), 5);
    chk("t2_fin", 64'(finished), 1);
    chk("t2_err", 64'(err), 0);

    // 3: DONE_CNT wraps 0xFFFF -> 0x0000 -> 0x0001
    done_cnt = 16'hFFFF;
    do_reset();
    snap = irq_cnt;
    start_run(0, LINE_WORDS, 4, 1'b0, 0);
    serve("t3_a0", 0);
    serve("t3_a1", 972);
    wait_start("t5_a2");
    chk("t5_a2", 64'(start_adr), 1944);
    chk("t3_irqs", 64'(irq_cnt - snap), 2);
    chk("t3_total", 64'(done_total), 2);
    chk("t3_err", 64'(err), 0);

    // 5: RUN drops with one command outstanding, then a spurious jump while idle
    @(posedge clk); #1 run = 1'b0;
    snap = start_cnt;
    repeat (10) @(negedge clk);
    chk("t5_nostart", 64'(start_cnt - snap), 0);
    chk("t5_busy_drain", 64'(busy), 1);
    complete_one();
    repeat (4) @(negedge clk);
    chk("t5_idle", 64'(busy), 0);
    chk("t5_total", 64'(done_total), 3);
    chk("t5_err0", 64'(err), 0);
    done_cnt = done_cnt + CNT_W'(2);
    repeat (3) @(negedge clk);
    chk("t5_err1", 64'(err), 1);

    // 4: TOTAL=3 issues exactly three buffers then finishes
    do_reset();
    snap = start_cnt;
    start_run(0, LINE_WORDS, 8, 1'b0, 3);
    serve("t4_a0", 0);
    serve("t4_a1", 972);
    serve("t4_a2", 1944);
    repeat (10) @(negedge clk);
    chk("t4_fin", 64'(finished), 1);
    chk("t4_busy", 64'(busy), 0);
    chk("t4_filled", 64'(filled), 3);
    repeat (10) @(negedge clk);
    chk("t4_nstart", 64'(start_cnt - snap), 3);

    // 6: release and completion in one cycle net out; SRST during ISSUE
    do_reset();
    start_run(0, LINE_WORDS, 4, 1'b0, 0);
    serve("t6_a0", 0);
    wait_start("t6_a1");
    chk("t6_a1", 64'(start_adr), 972);
    @(posedge clk); #1 done_cnt = done_cnt + CNT_W'(1); rel = 1'b1;
    @(posedge clk); #1 rel = 1'b0;
    @(negedge clk);
    chk("t6_filled_net", 64'(filled), 1);
    chk("t6_total", 64'(done_total), 2);
    wait_start("t6_a2");
    srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("t6_srst");
    srst = 1'b0;
    pulse_release();
    @(negedge clk);
    chk("t6_no_underflow", 64'(filled), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
